// File: rtl/axi_params_pkg.sv
// Shared AXI-Lite parameters, response encodings, register offsets and the
// address decode helper used by the register slave.
package axi_params_pkg;

   localparam int AXI_ADDR_WIDTH = 32;
   localparam int AXI_DATA_WIDTH = 32;

   typedef enum logic [1:0] {
      AXI_RESP_OKAY   = 2'b00,
      AXI_RESP_EXOKAY = 2'b01,
      AXI_RESP_SLVERR = 2'b10,
      AXI_RESP_DECERR = 2'b11
   } axi_resp_t;

   localparam logic [3:0] REG_CTRL_OFFSET     = 4'h0;
   localparam logic [3:0] REG_STATUS_OFFSET   = 4'h4;
   localparam logic [3:0] REG_DATA_IN_OFFSET  = 4'h8;
   localparam logic [3:0] REG_DATA_OUT_OFFSET = 4'hC;

   localparam int STATUS_BUSY_BIT = 0;
   localparam int STATUS_DONE_BIT = 1;

   typedef enum logic [1:0] {
      REG_IDX_CTRL     = 2'd0,
      REG_IDX_STATUS   = 2'd1,
      REG_IDX_DATA_IN  = 2'd2,
      REG_IDX_DATA_OUT = 2'd3
   } reg_idx_t;

   localparam logic [31:0] CTRL_WRITABLE_MASK = 32'h1;

   typedef struct packed {
      reg_idx_t  idx;
      axi_resp_t resp;
   } axi_decode_t;

   // Misalignment takes priority over out-of-range; read-only checks are left to the caller.
   function automatic axi_decode_t axi_decode_addr(input logic [3:0] addr_lo,
                                                   input logic       addr_hi_nz);
      axi_decode_t d;
      case ({addr_lo[3:2], 2'b00})
         REG_CTRL_OFFSET:     d.idx = REG_IDX_CTRL;
         REG_STATUS_OFFSET:   d.idx = REG_IDX_STATUS;
         REG_DATA_IN_OFFSET:  d.idx = REG_IDX_DATA_IN;
         REG_DATA_OUT_OFFSET: d.idx = REG_IDX_DATA_OUT;
         default:             d.idx = REG_IDX_CTRL;
      endcase
      if (addr_lo[1:0] != 2'b00) begin
         d.resp = AXI_RESP_SLVERR;
      end else if (addr_hi_nz) begin
         d.resp = AXI_RESP_DECERR;
      end else begin
         d.resp = AXI_RESP_OKAY;
      end
      return d;
   endfunction

endpackage

// File: rtl/axi_lite_reg_slave.sv
// AXI-Lite register front-end (CTRL/STATUS/DATA_IN/DATA_OUT) that launches a
// downstream datapath with a start pulse and captures its result on done.
module axi_lite_reg_slave
   import axi_params_pkg::*;
#(
   parameter int ADDR_WIDTH = AXI_ADDR_WIDTH,
   parameter int DATA_WIDTH = AXI_DATA_WIDTH
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [ADDR_WIDTH-1:0]   s_awaddr,
   input  logic                    s_awvalid,
   output logic                    s_awready,
   input  logic [DATA_WIDTH-1:0]   s_wdata,
   input  logic [DATA_WIDTH/8-1:0] s_wstrb,
   input  logic                    s_wvalid,
   output logic                    s_wready,
   output logic [1:0]              s_bresp,
   output logic                    s_bvalid,
   input  logic                    s_bready,
   input  logic [ADDR_WIDTH-1:0]   s_araddr,
   input  logic                    s_arvalid,
   output logic                    s_arready,
   output logic [DATA_WIDTH-1:0]   s_rdata,
   output logic [1:0]              s_rresp,
   output logic                    s_rvalid,
   input  logic                    s_rready,
   output logic                    proc_start,
   output logic [DATA_WIDTH-1:0]   proc_data,
   input  logic                    proc_done,
   input  logic [DATA_WIDTH-1:0]   proc_result
);

   logic                    aw_held_q, w_held_q;
   logic [ADDR_WIDTH-1:0]   awaddr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH/8-1:0] wstrb_q;
   logic                    bvalid_q, bvalid_d;
   axi_resp_t               bresp_q, bresp_d;
   logic                    rvalid_q, rvalid_d;
   axi_resp_t               rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
   logic [DATA_WIDTH-1:0]   ctrl_q, ctrl_d;
   logic [DATA_WIDTH-1:0]   data_in_q, data_in_d;
   logic [DATA_WIDTH-1:0]   data_out_q, data_out_d;
   logic                    busy_q, busy_d;
   logic                    done_q, done_d;
   logic                    start_q, start_d;

   logic                    aw_hs, w_hs, ar_hs, commit;
   logic [ADDR_WIDTH-1:0]   wr_addr;
   logic [DATA_WIDTH-1:0]   wr_data, byte_mask;
   logic [DATA_WIDTH/8-1:0] wr_strb;
   axi_decode_t             wr_dec, rd_dec;
   logic                    done_set, done_clr;

   assign s_awready  = !aw_held_q && !bvalid_q;
   assign s_wready   = !w_held_q && !bvalid_q;
   assign s_arready  = !rvalid_q;
   assign s_bvalid   = bvalid_q;
   assign s_bresp    = bresp_q;
   assign s_rvalid   = rvalid_q;
   assign s_rresp    = rresp_q;
   assign s_rdata    = rdata_q;
   assign proc_start = start_q;
   assign proc_data  = data_in_q;

   assign aw_hs   = s_awvalid && s_awready;
   assign w_hs    = s_wvalid && s_wready;
   assign ar_hs   = s_arvalid && s_arready;
   assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);
   assign wr_addr = aw_held_q ? awaddr_q : s_awaddr;
   assign wr_data = w_held_q ? wdata_q : s_wdata;
   assign wr_strb = w_held_q ? wstrb_q : s_wstrb;
   assign wr_dec  = axi_decode_addr(wr_addr[3:0], |wr_addr[ADDR_WIDTH-1:4]);
   assign rd_dec  = axi_decode_addr(s_araddr[3:0], |s_araddr[ADDR_WIDTH-1:4]);

   always_comb begin
      byte_mask = '0;
      for (int i = 0; i < DATA_WIDTH/8; i++) begin
         byte_mask[i*8 +: 8] = {8{wr_strb[i]}};
      end
   end

   // Write side: register updates, response code and datapath launch.
   always_comb begin
      ctrl_d    = ctrl_q;
      data_in_d = data_in_q;
      start_d   = 1'b0;
      bresp_d   = bresp_q;
      bvalid_d  = bvalid_q && !s_bready;
      if (commit) begin
         bvalid_d = 1'b1;
         bresp_d  = wr_dec.resp;
         if (wr_dec.resp == AXI_RESP_OKAY) begin
            case (wr_dec.idx)
               REG_IDX_CTRL: begin
                  ctrl_d = ((ctrl_q & ~byte_mask) | (wr_data & byte_mask))
                           & DATA_WIDTH'(CTRL_WRITABLE_MASK);
               end
               REG_IDX_DATA_IN: begin
                  if (busy_q) begin
                     bresp_d = AXI_RESP_SLVERR;
                  end else if (|wr_strb) begin
                     data_in_d = (data_in_q & ~byte_mask) | (wr_data & byte_mask);
                     start_d   = ctrl_q[0];
                  end
               end
               default: bresp_d = AXI_RESP_SLVERR;
            endcase
         end
      end
   end

   // Read side and status; a done set outranks a same-cycle clear.
   always_comb begin
      rvalid_d = rvalid_q && !s_rready;
      rresp_d  = rresp_q;
      rdata_d  = rdata_q;
      done_clr = 1'b0;
      if (ar_hs) begin
         rvalid_d = 1'b1;
         rresp_d  = rd_dec.resp;
         rdata_d  = '0;
         if (rd_dec.resp == AXI_RESP_OKAY) begin
            case (rd_dec.idx)
               REG_IDX_CTRL:    rdata_d = ctrl_q;
               REG_IDX_STATUS: begin
                  rdata_d[STATUS_BUSY_BIT] = busy_q;
                  rdata_d[STATUS_DONE_BIT] = done_q;
               end
               REG_IDX_DATA_IN: rdata_d = data_in_q;
               default: begin
                  rdata_d  = data_out_q;
                  done_clr = 1'b1;
               end
            endcase
         end
      end
      done_set   = proc_done && busy_q;
      data_out_d = done_set ? proc_result : data_out_q;
      busy_d     = start_d ? 1'b1 : (done_set ? 1'b0 : busy_q);
      done_d     = done_set ? 1'b1 : (done_clr ? 1'b0 : done_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         awaddr_q   <= '0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bvalid_q   <= 1'b0;
         bresp_q    <= AXI_RESP_OKAY;
         rvalid_q   <= 1'b0;
         rresp_q    <= AXI_RESP_OKAY;
         rdata_q    <= '0;
         ctrl_q     <= '0;
         data_in_q  <= '0;
         data_out_q <= '0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         start_q    <= 1'b0;
      end else begin
         if (commit) begin
            aw_held_q <= 1'b0;
            w_held_q  <= 1'b0;
         end else begin
            if (aw_hs) begin
               aw_held_q <= 1'b1;
               awaddr_q  <= s_awaddr;
            end
            if (w_hs) begin
               w_held_q <= 1'b1;
               wdata_q  <= s_wdata;
               wstrb_q  <= s_wstrb;
            end
         end
         bvalid_q   <= bvalid_d;
         bresp_q    <= bresp_d;
         rvalid_q   <= rvalid_d;
         rresp_q    <= rresp_d;
         rdata_q    <= rdata_d;
         ctrl_q     <= ctrl_d;
         data_in_q  <= data_in_d;
         data_out_q <= data_out_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         start_q    <= start_d;
      end
   end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: inputs change on the falling edge,
// outputs are sampled on the falling edge, expected values are hand-computed.
module tb_axi_lite_reg_slave;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] s_awaddr;
   logic        s_awvalid;
   logic        s_awready;
   logic [31:0] s_wdata;
   logic [3:0]  s_wstrb;
   logic        s_wvalid;
   logic        s_wready;
   logic [1:0]  s_bresp;
   logic        s_bvalid;
   logic        s_bready;
   logic [31:0] s_araddr;
   logic        s_arvalid;
   logic        s_arready;
   logic [31:0] s_rdata;
   logic [1:0]  s_rresp;
   logic        s_rvalid;
   logic        s_rready;
   logic        proc_start;
   logic [31:0] proc_data;
   logic        proc_done;
   logic [31:0] proc_result;

   int n_cmp = 0;
   int n_err = 0;

   localparam logic [1:0] OKAY = 2'b00, SLVERR = 2'b10, DECERR = 2'b11;

   always #5 clk = ~clk;

   axi_lite_reg_slave dut (
      .clk(clk), .rst(rst),
      .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
      .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
      .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
      .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
      .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
      .proc_start(proc_start), .proc_data(proc_data),
      .proc_done(proc_done), .proc_result(proc_result)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Single write with AW and W together; B is sampled one cycle after commit.
   task automatic axi_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] exp_resp,
                            input logic exp_start);
      @(negedge clk);
      chk({tag, ".awready"}, 32'(s_awready), 32'd1);
      chk({tag, ".wready"}, 32'(s_wready), 32'd1);
      s_awaddr = addr; s_awvalid = 1'b1;
      s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_awvalid = 1'b0; s_wvalid = 1'b0;
      chk({tag, ".bvalid"}, 32'(s_bvalid), 32'd1);
      chk({tag, ".bresp"}, 32'(s_bresp), 32'(exp_resp));
      chk({tag, ".start"}, 32'(proc_start), 32'(exp_start));
      s_bready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_bready = 1'b0;
      chk({tag, ".bdone"}, 32'(s_bvalid), 32'd0);
      chk({tag, ".start_off"}, 32'(proc_start), 32'd0);
   endtask

   task automatic axi_read(input string tag, input logic [31:0] addr,
                           input logic [31:0] exp_data, input logic [1:0] exp_resp);
      @(negedge clk);
      chk({tag, ".arready"}, 32'(s_arready), 32'd1);
      s_araddr = addr; s_arvalid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_arvalid = 1'b0;
      chk({tag, ".rvalid"}, 32'(s_rvalid), 32'd1);
      chk({tag, ".rdata"}, s_rdata, exp_data);
      chk({tag, ".rresp"}, 32'(s_rresp), 32'(exp_resp));
      s_rready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      s_rready = 1'b0;
      chk({tag, ".rdone"}, 32'(s_rvalid), 32'd0);
   endtask

   task automatic pulse_done(input logic [31:0] result);
      @(negedge clk);
      proc_done = 1'b1; proc_result = result;
      @(negedge clk);
      proc_done = 1'b0; proc_result = '0;
   endtask

   initial begin
      rst = 1'b1;
      s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
      s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
      proc_done = 1'b0; proc_result = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst.bvalid", 32'(s_bvalid), 32'd0);
      chk("rst.rvalid", 32'(s_rvalid), 32'd0);
      chk("rst.start", 32'(proc_start), 32'd0);
      chk("rst.pdata", proc_data, 32'd0);
      chk("rst.rdata", s_rdata, 32'd0);
      chk("rst.awready", 32'(s_awready), 32'd1);
      chk("rst.wready", 32'(s_wready), 32'd1);
      chk("rst.arready", 32'(s_arready), 32'd1);

      // Only the enable bit of CTRL is writable
      axi_write("ctrl_wr", 32'h0, 32'hFFFF_FFFF, 4'hF, OKAY, 1'b0);
      axi_read("ctrl_rd", 32'h0, 32'h0000_0001, OKAY);

      axi_write("din_start", 32'h8, 32'hA5A5_0001, 4'hF, OKAY, 1'b1);
      chk("din_start.pdata", proc_data, 32'hA5A5_0001);
      axi_read("stat_busy", 32'h4, 32'h1, OKAY);

      axi_write("din_busy", 32'h8, 32'h0000_DEAD, 4'hF, SLVERR, 1'b0);
      axi_read("din_keep", 32'h8, 32'hA5A5_0001, OKAY);

      pulse_done(32'h0000_1234);
      axi_read("stat_done", 32'h4, 32'h2, OKAY);
      axi_read("dout_rd", 32'hC, 32'h0000_1234, OKAY);
      axi_read("stat_clr", 32'h4, 32'h0, OKAY);

      axi_read("decerr_rd", 32'h10, 32'h0, DECERR);
      axi_write("misalign_wr", 32'h6, 32'h1, 4'hF, SLVERR, 1'b0);
      axi_write("stat_wr", 32'h4, 32'hFF, 4'hF, SLVERR, 1'b0);
      axi_read("stat_ro", 32'h4, 32'h0, OKAY);
      axi_write("dout_wr", 32'hC, 32'hFF, 4'hF, SLVERR, 1'b0);
      axi_read("dout_ro", 32'hC, 32'h0000_1234, OKAY);

      // With enable off, DATA_IN updates but nothing launches
      axi_write("ctrl_off", 32'h0, 32'h0, 4'hF, OKAY, 1'b0);
      axi_write("din_zero", 32'h8, 32'h0, 4'hF, OKAY, 1'b0);
      axi_write("din_strb", 32'h8, 32'hFFFF_FFFF, 4'b0010, OKAY, 1'b0);
      axi_read("din_strb_rd", 32'h8, 32'h0000_FF00, OKAY);
      axi_write("din_nostrb", 32'h8, 32'hFFFF_FFFF, 4'b0000, OKAY, 1'b0);
      axi_read("din_nostrb_rd", 32'h8, 32'h0000_FF00, OKAY);

      // W leads AW by three cycles, then B is back-pressured for four cycles
      @(negedge clk);
      s_wdata = 32'h1122_3344; s_wstrb = 4'hF; s_wvalid = 1'b1;
      @(negedge clk);
      s_wvalid = 1'b0;
      chk("skew.wready_held", 32'(s_wready), 32'd0);
      chk("skew.awready_open", 32'(s_awready), 32'd1);
      chk("skew.no_b", 32'(s_bvalid), 32'd0);
      repeat (2) @(negedge clk);
      s_awaddr = 32'h8; s_awvalid = 1'b1;
      @(negedge clk);
      s_awvalid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("skew.bvalid_hold", 32'(s_bvalid), 32'd1);
         chk("skew.bresp_hold", 32'(s_bresp), 32'(OKAY));
         chk("skew.awready_low", 32'(s_awready), 32'd0);
         chk("skew.wready_low", 32'(s_wready), 32'd0);
         @(negedge clk);
      end
      s_bready = 1'b1;
      @(negedge clk);
      s_bready = 1'b0;
      chk("skew.bdone", 32'(s_bvalid), 32'd0);
      @(negedge clk);
      chk("skew.single_b", 32'(s_bvalid), 32'd0);
      chk("skew.awready_back", 32'(s_awready), 32'd1);
      axi_read("skew.din", 32'h8, 32'h1122_3344, OKAY);

      // Reset while busy with a read response outstanding
      axi_write("rst_en", 32'h0, 32'h1, 4'hF, OKAY, 1'b0);
      axi_write("rst_go", 32'h8, 32'h0000_0055, 4'hF, OKAY, 1'b1);
      @(negedge clk);
      s_araddr = 32'h4; s_arvalid = 1'b1;
      @(negedge clk);
      s_arvalid = 1'b0;
      chk("rst_mid.rvalid_pre", 32'(s_rvalid), 32'd1);
      chk("rst_mid.rdata_pre", s_rdata, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid.bvalid", 32'(s_bvalid), 32'd0);
      chk("rst_mid.rvalid", 32'(s_rvalid), 32'd0);
      chk("rst_mid.start", 32'(proc_start), 32'd0);
      pulse_done(32'h0000_0BAD);
      axi_read("rst_mid.status", 32'h4, 32'h0, OKAY);
      axi_read("rst_mid.dout", 32'hC, 32'h0, OKAY);
      axi_read("rst_mid.ctrl", 32'h0, 32'h0, OKAY);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/axi_lite_reg_slave.md
# axi_lite_reg_slave

AXI-Lite slave front-end that implements the CTRL/STATUS/DATA_IN/DATA_OUT register map and drives a downstream processing datapath through a start/done handshake. It sits between the SoC AXI-Lite interconnect and the processing core. It uses the shared AXI parameters, response encodings and register offsets from `axi_params_pkg`.

## Interface
- `ADDR_WIDTH`, default `AXI_ADDR_WIDTH` (32): AXI address width.
- `DATA_WIDTH`, default `AXI_DATA_WIDTH` (32): AXI data width. Only 32 is supported.
- `clk`, in, 1: single clock. One clock; reset is synchronous and active-high.
- `rst`, in, 1: synchronous, active-high reset.
- `s_awaddr` / `s_awvalid` / `s_awready`, in/in/out, ADDR_WIDTH/1/1: write address channel.
- `s_wdata` / `s_wstrb` / `s_wvalid` / `s_wready`, in/in/in/out, DATA_WIDTH/DATA_WIDTH/8/1/1: write data channel.
- `s_bresp` / `s_bvalid` / `s_bready`, out/out/in, 2/1/1: write response channel.
- `s_araddr` / `s_arvalid` / `s_arready`, in/in/out, ADDR_WIDTH/1/1: read address channel.
- `s_rdata` / `s_rresp` / `s_rvalid` / `s_rready`, out/out/out/in, DATA_WIDTH/2/1/1: read data channel.
- `proc_start`, out, 1: one-cycle pulse that launches a datapath operation.
- `proc_data`, out, DATA_WIDTH: operand, equal to the DATA_IN register.
- `proc_done`, in, 1: one-cycle pulse from the datapath when the result is ready.
- `proc_result`, in, DATA_WIDTH: result, valid while `proc_done` is high.

## Operation
- **Address decode.** Let `idx = addr[3:2]` (`WORD_ADDR_LSB`).
  - `addr[1:0] != 0` → SLVERR.
  - Any bit in `addr[ADDR_WIDTH-1:4]` set → DECERR.
  - Otherwise OKAY, except for the read-only violations listed below.
- **Registers.** All reset to 0.
  - CTRL (0x0): bit0 is enable (R/W). Bits 31:1 read as 0 and ignore writes.
  - STATUS (0x4): read-only. bit0 = busy, bit1 = done (sticky).
  - DATA_IN (0x8): R/W with byte strobes.
  - DATA_OUT (0xC): read-only. Holds the last captured `proc_result`.
- **Read-only violations.** A write to STATUS or DATA_OUT returns SLVERR and changes nothing.
- **Write channel.**
  - AW and W are accepted independently.
  - `s_awready = !aw_held && !s_bvalid`; `s_wready = !w_held && !s_bvalid`.
  - The write commits at the clock edge where both are held (or both handshake in the same cycle).
  - `s_bvalid` rises the next cycle and holds until `s_bready`.
- **Write strobes.** `s_wstrb` masks byte lanes of CTRL and DATA_IN. An all-zero strobe is OKAY with no change.
- **DATA_IN write while busy.** Returns SLVERR; the register is unchanged and no start is issued.
- **DATA_IN write with enable=1, not busy.** Returns OKAY and updates the register.
  - `proc_start` pulses in the same cycle `s_bvalid` rises.
  - `proc_data` carries the new value.
  - busy sets in that same cycle.
- **DATA_IN write with enable=0.** Returns OKAY and updates the register; no start is issued.
- **Result capture.** `proc_done` while busy loads DATA_OUT from `proc_result`, clears busy and sets done. `proc_done` while not busy is ignored.
- **done flag.** Cleared by a successful read of DATA_OUT. If a set and a clear fall in the same cycle, set wins.
- **Disable during operation.** Clearing enable while busy does not abort; the pending result is still captured.
- **Read channel.**
  - `s_arready = !s_rvalid`.
  - On AR handshake, `s_rdata`/`s_rresp` are registered from the current register state.
  - `s_rvalid` rises the next cycle and holds until `s_rready`.
  - Error reads return `s_rdata` = 0.

## Timing
- **Reset values.**
  - `s_bvalid`, `s_rvalid`, `proc_start`: 0.
  - `s_rdata`, `s_bresp`, `s_rresp`, `proc_data`: 0.
  - `s_awready`, `s_wready`, `s_arready`: 1 in the first cycle after `rst` deasserts.
- **Write latency.** 1 cycle from commit to `s_bvalid`. Back-to-back writes sustain one per 2 cycles when `s_bready` is held high.
- **Read latency.** 1 cycle from AR handshake to `s_rvalid`. Throughput is one read per 2 cycles.
- **Read/write interaction.**
  - Reads and writes proceed concurrently.
  - A read accepted in the same cycle as a write commit returns the pre-write value.
  - A DATA_OUT read accepted in the same cycle as `proc_done` returns the old DATA_OUT and does not clear done.
- **Reset mid-operation.** Pending AW/W, outstanding B/R, busy and done are all dropped. A stale `proc_done` after reset is ignored because busy = 0.
- **Handshake rules.** Outputs are held stable while valid is high and ready is low. `proc_start` is never high for two consecutive cycles.

## Structure
- **Add to `axi_params_pkg`:**
  - `STATUS_DONE_BIT = 1`.
  - A 2-bit register-index enum (`REG_IDX_CTRL` … `REG_IDX_DATA_OUT`).
  - `CTRL_WRITABLE_MASK = 32'h1`.
- **Reused from the package:** `axi_resp_t` and the `REG_*_OFFSET` constants. Local response constants must not be redefined.
- **Module split:** single module `axi_lite_reg_slave`; no sub-module. Decode is a package function `axi_decode_addr`, which returns index and response.

## Test plan
- **Basic write/read.** Write CTRL = 0xFFFF_FFFF, then read CTRL → 0x0000_0001, OKAY; B and R each arrive 1 cycle after commit/AR.
- **Start/done.** With enable=1, write DATA_IN = 0xA5A5_0001 → `proc_start` for 1 cycle, `proc_data` = 0xA5A5_0001, STATUS = 0x1. Then `proc_done` with result 0x1234 → STATUS = 0x2. Read DATA_OUT → 0x1234, and STATUS then reads 0x0.
- **Busy write.** A second DATA_IN write while busy → SLVERR, DATA_IN unchanged, no `proc_start`.
- **Errors.** Read 0x10 → DECERR, rdata 0. Write 0x6 → SLVERR. Write STATUS → SLVERR, no change. wstrb = 4'b0010 on DATA_IN = 0 with data 0xFFFF_FFFF → 0x0000_FF00.
- **Channel skew.** W presented 3 cycles before AW with `s_bready` low for 4 cycles → single B, OKAY, held stable. AW/W readies stay low until B completes.
- **Reset mid-operation.** Assert `rst` while busy and with `s_rvalid` high → all valids 0, STATUS 0, and a later `proc_done` leaves DATA_OUT = 0.
